// File: rtl/dw3_22_calc_pkg.sv
// Shared Q6.10 constants, saturation helper and FSM state encoding for dw3_22_calc.
package dw3_22_calc_pkg;

    localparam int FRAC_BITS = 10;
    localparam logic signed [15:0] Q_MAX = 16'sh7FFF;
    localparam logic signed [15:0] Q_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        SCALE = 2'd2,
        ACC   = 2'd3
    } state_e;

    // Clamp a 32-bit signed value into the signed 16-bit Q6.10 range.
    function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
        logic signed [15:0] r;
        if (v > 32'sh0000_7FFF) begin
            r = Q_MAX;
        end else if (v < 32'shFFFF_8000) begin
            r = Q_MIN;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/dw3_22_calc_qmul_sat.sv
// Combinational Q6.10 multiply: full product, floor shift by FRAC_BITS, saturate to 16 bits.
module qmul_sat
    import dw3_22_calc_pkg::*;
(
    input  logic signed [15:0] a_i,
    input  logic signed [15:0] b_i,
    output logic signed [15:0] p_o
);

    logic signed [31:0] prod_s;
    logic signed [31:0] shift_s;

    // Arithmetic shift floors toward minus infinity, so negative results never round up.
    assign prod_s  = a_i * b_i;
    assign shift_s = prod_s >>> FRAC_BITS;
    assign p_o     = sat16(shift_s);

endmodule

// File: rtl/dw3_22_calc.sv
// Delta-weight generator for w3_22: dw = -ETA * delta3_2 * a2_2, accumulated over BATCH samples.
module dw3_22_calc
    import dw3_22_calc_pkg::*;
#(
    parameter logic signed [15:0] ETA   = 16'sh0200,
    parameter int                 BATCH = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    output logic        ready_in,
    input  logic [15:0] delta3_2,
    input  logic [15:0] a2_2,
    input  logic        flush,
    output logic [15:0] dw3_22,
    output logic        select_update,
    output logic [7:0]  count
);

    localparam logic [7:0] BATCH_C = 8'(BATCH);

    state_e             state_q, state_d;
    logic signed [15:0] delta_q, delta_d;
    logic signed [15:0] a_q, a_d;
    logic signed [15:0] p1_q, p1_d;
    logic signed [15:0] p2_q, p2_d;
    logic signed [23:0] acc_q, acc_d;
    logic [7:0]         count_q, count_d;
    logic [15:0]        dw_q, dw_d;
    logic               sel_q, sel_d;
    logic               ready_q, ready_d;

    logic signed [15:0] mul_s;
    logic signed [15:0] scale_s;
    logic signed [15:0] p2_neg_s;
    logic signed [23:0] acc_new_s;

    qmul_sat u_mul (
        .a_i (delta_q),
        .b_i (a_q),
        .p_o (mul_s)
    );

    qmul_sat u_scale (
        .a_i (p1_q),
        .b_i (ETA),
        .p_o (scale_s)
    );

    // Negation of the most negative value saturates instead of wrapping back to itself.
    assign p2_neg_s  = (p2_q == Q_MIN) ? Q_MAX : -p2_q;
    assign acc_new_s = acc_q + {{8{p2_neg_s[15]}}, p2_neg_s};

    // Next-state, datapath and update-pulse logic for the four-phase sample pipeline.
    always_comb begin
        state_d = state_q;
        delta_d = delta_q;
        a_d     = a_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        acc_d   = acc_q;
        count_d = count_q;
        dw_d    = dw_q;
        sel_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    delta_d = delta3_2;
                    a_d     = a2_2;
                    state_d = MUL;
                end else if (flush && (count_q != 8'd0)) begin
                    dw_d    = sat16({{8{acc_q[23]}}, acc_q});
                    sel_d   = 1'b1;
                    acc_d   = 24'sd0;
                    count_d = 8'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                p1_d    = mul_s;
                state_d = SCALE;
            end
            SCALE: begin
                p2_d    = scale_s;
                state_d = ACC;
            end
            ACC: begin
                state_d = IDLE;
                if ((count_q + 8'd1) == BATCH_C) begin
                    dw_d    = sat16({{8{acc_new_s[23]}}, acc_new_s});
                    sel_d   = 1'b1;
                    acc_d   = 24'sd0;
                    count_d = 8'd0;
                end else begin
                    acc_d   = acc_new_s;
                    count_d = count_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    // State and datapath registers with synchronous reset; a partial batch is dropped on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            delta_q <= 16'sd0;
            a_q     <= 16'sd0;
            p1_q    <= 16'sd0;
            p2_q    <= 16'sd0;
            acc_q   <= 24'sd0;
            count_q <= 8'd0;
            dw_q    <= 16'd0;
            sel_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            delta_q <= delta_d;
            a_q     <= a_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            dw_q    <= dw_d;
            sel_q   <= sel_d;
            ready_q <= ready_d;
        end
    end

    assign ready_in      = ready_q;
    assign dw3_22        = dw_q;
    assign select_update = sel_q;
    assign count         = count_q;

endmodule

// File: tb/tb_dw3_22_calc.sv
// Self-checking bench for dw3_22_calc: a BATCH=1 and a BATCH=4 instance against an arithmetic model.
module tb_dw3_22_calc;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_s;
    logic        flush_s;
    logic        use4;
    logic [15:0] delta_s;
    logic [15:0] a_s;

    logic        ready1, sel1, ready4, sel4;
    logic [15:0] dw1, dw4;
    logic [7:0]  cnt1, cnt4;

    logic        ready_m, sel_m;
    logic [15:0] dw_m;
    logic [7:0]  cnt_m;

    int          total = 0;
    int          bad   = 0;

    int          m_acc;
    int          m_cnt;
    int          m_batch;
    logic [15:0] m_dw;

    always #5 clk = ~clk;

    dw3_22_calc #(.ETA(16'sh0200), .BATCH(1)) u_dut1 (
        .clk           (clk),
        .reset         (reset),
        .valid_in      (valid_s & ~use4),
        .ready_in      (ready1),
        .delta3_2      (delta_s),
        .a2_2          (a_s),
        .flush         (flush_s & ~use4),
        .dw3_22        (dw1),
        .select_update (sel1),
        .count         (cnt1)
    );

    dw3_22_calc #(.ETA(16'sh0200), .BATCH(4)) u_dut4 (
        .clk           (clk),
        .reset         (reset),
        .valid_in      (valid_s & use4),
        .ready_in      (ready4),
        .delta3_2      (delta_s),
        .a2_2          (a_s),
        .flush         (flush_s & use4),
        .dw3_22        (dw4),
        .select_update (sel4),
        .count         (cnt4)
    );

    assign ready_m = use4 ? ready4 : ready1;
    assign sel_m   = use4 ? sel4   : sel1;
    assign dw_m    = use4 ? dw4    : dw1;
    assign cnt_m   = use4 ? cnt4   : cnt1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int clamp16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    // Real-number Q6.10 product: floor(a*b / 1024), then clamp.
    function automatic int q_mul(input int a, input int b);
        longint p, q;
        p = longint'(a) * longint'(b);
        if (p >= 0) q = p / 1024;
        else        q = -((-p + 1023) / 1024);
        return clamp16(q);
    endfunction

    // Caller is at a negedge; sample is accepted at the next posedge.
    task automatic do_sample(input logic [15:0] d, input logic [15:0] a, input logic fl, input string tag);
        int          p1, p2;
        logic        exp_pulse;
        logic [15:0] old_dw;
        int          old_cnt;
        check({tag, "_ready_idle"}, 32'(ready_m), 32'd1);
        valid_s = 1'b1;
        flush_s = fl;
        delta_s = d;
        a_s     = a;
        @(posedge clk);
        #1;
        valid_s = 1'b0;
        flush_s = 1'b0;
        delta_s = 16'($urandom);
        a_s     = 16'($urandom);
        old_dw  = m_dw;
        old_cnt = m_cnt;
        p1 = q_mul(int'($signed(d)), int'($signed(a)));
        p2 = q_mul(p1, 512);
        m_acc = m_acc + ((p2 == -32768) ? 32767 : -p2);
        exp_pulse = 1'b0;
        if (m_cnt + 1 == m_batch) begin
            m_dw      = 16'(clamp16(m_acc));
            m_acc     = 0;
            m_cnt     = 0;
            exp_pulse = 1'b1;
        end else begin
            m_cnt++;
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check({tag, "_ready_busy"}, 32'(ready_m), 32'd0);
            check({tag, "_sel_busy"}, 32'(sel_m), 32'd0);
            check({tag, "_dw_busy"}, 32'(dw_m), 32'(old_dw));
            check({tag, "_cnt_busy"}, 32'(cnt_m), 32'(old_cnt));
        end
        @(negedge clk);
        check({tag, "_ready_done"}, 32'(ready_m), 32'd1);
        check({tag, "_sel"}, 32'(sel_m), 32'(exp_pulse));
        check({tag, "_dw"}, 32'(dw_m), 32'(m_dw));
        check({tag, "_cnt"}, 32'(cnt_m), 32'(m_cnt));
    endtask

    task automatic do_flush(input string tag);
        logic exp_pulse;
        check({tag, "_ready_idle"}, 32'(ready_m), 32'd1);
        flush_s = 1'b1;
        @(posedge clk);
        #1;
        flush_s   = 1'b0;
        exp_pulse = (m_cnt > 0);
        if (exp_pulse) begin
            m_dw  = 16'(clamp16(m_acc));
            m_acc = 0;
            m_cnt = 0;
        end
        @(negedge clk);
        check({tag, "_sel"}, 32'(sel_m), 32'(exp_pulse));
        check({tag, "_dw"}, 32'(dw_m), 32'(m_dw));
        check({tag, "_cnt"}, 32'(cnt_m), 32'(m_cnt));
        check({tag, "_ready"}, 32'(ready_m), 32'd1);
        @(negedge clk);
        check({tag, "_sel_off"}, 32'(sel_m), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_acc = 0;
        m_cnt = 0;
        m_dw  = 16'd0;
        @(negedge clk);
        check({tag, "_dw"}, 32'(dw_m), 32'd0);
        check({tag, "_sel"}, 32'(sel_m), 32'd0);
        check({tag, "_ready"}, 32'(ready_m), 32'd1);
        check({tag, "_cnt"}, 32'(cnt_m), 32'd0);
    endtask

    initial begin
        logic [15:0] rd, ra;
        int          r;
        reset   = 1'b1;
        valid_s = 1'b0;
        flush_s = 1'b0;
        delta_s = 16'd0;
        a_s     = 16'd0;
        use4    = 1'b0;
        m_batch = 1;
        @(negedge clk);
        do_reset("rst1");

        do_sample(16'h0400, 16'h0200, 1'b0, "basic");
        check("basic_lit", 32'(dw_m), 32'h0000_FF00);
        do_sample(16'h7C00, 16'h7C00, 1'b0, "sat");
        check("sat_lit", 32'(dw_m), 32'h0000_C001);
        do_sample(16'hFFFF, 16'h0001, 1'b0, "floor");
        check("floor_lit", 32'(dw_m), 32'h0000_0001);

        use4    = 1'b1;
        m_batch = 4;
        do_reset("rst4");
        for (int i = 0; i < 4; i++) do_sample(16'h0400, 16'h0200, 1'b0, "batch");
        check("batch_lit", 32'(dw_m), 32'h0000_FC00);
        check("batch_cnt0", 32'(cnt_m), 32'd0);

        do_sample(16'h0400, 16'h0200, 1'b0, "fl_s1");
        do_sample(16'h0400, 16'h0200, 1'b0, "fl_s2");
        do_flush("flush1");
        check("flush_lit", 32'(dw_m), 32'h0000_FE00);
        do_flush("flush_empty");
        do_sample(16'h0400, 16'h0200, 1'b1, "flush_valid");
        check("flush_valid_cnt", 32'(cnt_m), 32'd1);

        // Reset while the sample sits in SCALE.
        valid_s = 1'b1;
        delta_s = 16'h0400;
        a_s     = 16'h0200;
        @(posedge clk);
        #1;
        valid_s = 1'b0;
        @(negedge clk);
        @(negedge clk);
        do_reset("rst_mid");
        for (int i = 0; i < 4; i++) do_sample(16'h0400, 16'h0200, 1'b0, "post_rst");
        check("post_rst_lit", 32'(dw_m), 32'h0000_FC00);

        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                do_flush("rnd_flush");
            end else if (r == 9) begin
                do_reset("rnd_rst");
            end else begin
                rd = 16'($urandom);
                ra = 16'($urandom);
                if ($urandom_range(0, 1) == 1) rd = {{6{rd[9]}}, rd[9:0]};
                if ($urandom_range(0, 1) == 1) ra = {{6{ra[9]}}, ra[9:0]};
                do_sample(rd, ra, (r == 2), "rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
